trackball_quad_gen: RTL
=======================

// Module: trackball_quad_gen
// PURPOSE
//  Converts signed per-frame mouse/analog deltas (X,Y) from the HPS input path into rate-limited
//  quadrature A/B pairs that drive the trackball quadrature decoder inputs.
//  One instance per player; sits directly upstream of the LETA X/Y inputs.
//  Buffers deltas in per-axis accumulators and drains them one quadrature edge at a time.
// PARAMETERS
//  DELTA_W   8    width of signed input deltas (two's complement)
//  ACC_W     10   width of signed per-axis accumulator
//  STEP_DIV  16   ce pulses between successive quadrature edges (>=2)
// PORTS
//  clk          in   1        system clock
//  reset_n      in   1        asynchronous active-low reset
//  ce           in   1        clock enable tick; divider advances only when ce=1
//  delta_valid  in   1        delta_x/delta_y valid this cycle
//  delta_ready  out  1        block can accept a delta this cycle
//  delta_x      in   DELTA_W  signed X movement, in quadrature edges
//  delta_y      in   DELTA_W  signed Y movement, in quadrature edges
//  xa, xb       out  1        X-axis quadrature pair
//  ya, yb       out  1        Y-axis quadrature pair
//  busy         out  1        either accumulator nonzero
// BEHAVIOUR
//  Reset: acc_x=acc_y=0, phase_x=phase_y=0, divider=0; xa=xb=ya=yb=0, busy=0, delta_ready=1.
//  Handshake: delta accepted on posedge when delta_valid & delta_ready; no partial accept.
//  delta_ready=1 iff both accs lie in [-LIM, LIM-1], LIM = 2^(ACC_W-1) - 2^(DELTA_W-1)
//    (defaults: [-384,383]), so acc+delta never overflows; combinational from acc registers only.
//  Divider: counts ce pulses 0..STEP_DIV-1; step_tick = ce & (div==STEP_DIV-1); div wraps to 0.
//  On step_tick, per axis independently: acc>0 -> phase+1, acc-1; acc<0 -> phase-1, acc+1;
//    acc==0 -> no change.
//  Phase -> {A,B}: 0:00, 1:10, 2:11, 3:01. phase+1 wraps 3->0 and is counted UP by the decoder;
//    phase-1 wraps 0->3. Exactly one of A/B changes per step (no glitches).
//  Outputs registered directly from phase (1-cycle latency after step_tick).
//  Simultaneous accept and step: acc_next = acc + sext(delta) - sign_step, in a single cycle.
//  A delta of 0 is accepted and leaves acc unchanged.
//  busy = (acc_x!=0)|(acc_y!=0), registered-derived.
//  Reset mid-operation: accs discarded; A/B return to 00 (decoder sees at most one edge).
//  Divider is not reset by accepts; with ce=0 the block holds all state.
// CONFIGURATION
//  TRACKBALL_ACCEL_EN defined: any axis with |acc| > 64 uses the fast rate for the whole block,
//    step_tick = ce & (div[1:0]==3 or div==STEP_DIV-1); drains large flicks 4x faster.
//  Not defined: fixed rate, one edge per STEP_DIV ce pulses.
// STRUCTURE
//  Shared package (cc_pkg): quadrature phase encoding table, LIM computation function,
//    accel threshold constant (64).
//  Sub-module quad_axis (acc + phase + A/B regs, one per axis), instanced twice; top holds
//    the divider, handshake and busy logic.
// TESTING
//  1 STEP_DIV=4, ce=1, delta_x=+3 once -> {xa,xb} 00->10->11->01, edges 4 clk apart; busy drops after 3rd.
//  2 delta_y=-2 -> {ya,yb} 00->01->11; downstream decoder count decreases by 2 edges; X stays 00.
//  3 Five deltas_x=+127 back-to-back -> ready low once acc_x>383; no overflow; all accepted edges emitted.
//  4 delta accepted on a step_tick cycle with acc_x=5, delta=+2 -> acc_x=6 next cycle.
//  5 reset_n low mid-drain (acc_x=20) -> outputs 00, busy=0 immediately; ready=1.
//  6 ce held 0 with acc_x=10 -> no edges; resumes at same divider count when ce returns.

Source files
------------

// File: rtl/cc_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : cc_pkg                                                         |
// | Description : Shared helpers for the trackball quadrature generator:        |
// |               quadrature phase encoding, accumulator headroom limit and     |
// |               acceleration threshold.                                       |
// | Revision    : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
package cc_pkg;

    // |acc| above this switches the whole block to the fast drain rate
    localparam int c_accel_thresh = 64;

    // Phase to {A,B}: 0:00, 1:10, 2:11, 3:01 (Gray sequence, one bit per step)
    function automatic logic [1:0] quad_enc(input logic [1:0] phase);
        logic [1:0] ab;
        case (phase)
            2'd0:    ab = 2'b00;
            2'd1:    ab = 2'b10;
            2'd2:    ab = 2'b11;
            default: ab = 2'b01;
        endcase
        return ab;
    endfunction

    // Largest magnitude an accumulator may hold and still absorb any delta
    function automatic int lim_calc(input int acc_w, input int delta_w);
        return (1 << (acc_w - 1)) - (1 << (delta_w - 1));
    endfunction

endpackage
`default_nettype wire

// File: rtl/quad_axis.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : quad_axis                                                      |
// | Description : One axis of the quadrature generator: signed accumulator,     |
// |               2-bit phase counter and registered A/B outputs. Each step     |
// |               moves the phase one position toward draining the accumulator. |
// | Revision    : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module quad_axis
    import cc_pkg::*;
#(
    parameter int DELTA_W = 8,
    parameter int ACC_W   = 10
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    i_step,
    input  logic                    i_load,
    input  logic [DELTA_W-1:0]      i_delta,
    output logic                    o_a,
    output logic                    o_b,
    output logic signed [ACC_W-1:0] o_acc
);

    logic signed [ACC_W-1:0] r_acc;
    logic signed [ACC_W-1:0] w_acc_next;
    logic signed [ACC_W-1:0] w_add;
    logic signed [ACC_W-1:0] w_sub;
    logic [1:0]              r_phase;
    logic [1:0]              w_phase_next;
    logic [1:0]              r_ab;
    logic                    w_pos;
    logic                    w_neg;

    assign w_neg = r_acc[ACC_W-1];
    assign w_pos = !r_acc[ACC_W-1] && (r_acc != '0);

    // Accept and step may coincide: add the new delta and drain one edge together
    always_comb begin
        w_add        = '0;
        w_sub        = '0;
        w_phase_next = r_phase;
        if (i_load) begin
            w_add = {{(ACC_W-DELTA_W){i_delta[DELTA_W-1]}}, i_delta};
        end
        if (i_step && w_pos) begin
            w_sub        = ACC_W'(1);
            w_phase_next = r_phase + 2'd1;
        end else if (i_step && w_neg) begin
            w_sub        = '1;
            w_phase_next = r_phase - 2'd1;
        end
        w_acc_next = r_acc + w_add - w_sub;
    end

    // Accumulator, phase and A/B registers; A/B follow the new phase directly
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_acc   <= '0;
            r_phase <= 2'd0;
            r_ab    <= 2'b00;
        end else begin
            r_acc   <= w_acc_next;
            r_phase <= w_phase_next;
            r_ab    <= quad_enc(w_phase_next);
        end
    end

    assign o_a   = r_ab[1];
    assign o_b   = r_ab[0];
    assign o_acc = r_acc;

endmodule
`default_nettype wire

// File: rtl/trackball_quad_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : trackball_quad_gen                                             |
// | Description : Converts signed per-frame X/Y deltas into rate-limited        |
// |               quadrature A/B pairs for the trackball decoder. Holds the     |
// |               step divider, input handshake and busy flag.                  |
// |               Optional macro TRACKBALL_ACCEL_EN: 4x drain rate while any    |
// |               accumulator magnitude exceeds the acceleration threshold.     |
// | Revision    : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module trackball_quad_gen
    import cc_pkg::*;
#(
    parameter int DELTA_W  = 8,
    parameter int ACC_W    = 10,
    parameter int STEP_DIV = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               ce,
    input  logic               delta_valid,
    output logic               delta_ready,
    input  logic [DELTA_W-1:0] delta_x,
    input  logic [DELTA_W-1:0] delta_y,
    output logic               xa,
    output logic               xb,
    output logic               ya,
    output logic               yb,
    output logic               busy
);

    // Divider is at least 2 bits so the fast-rate test on div[1:0] is always legal
    localparam int c_div_w = ($clog2(STEP_DIV) < 2) ? 2 : $clog2(STEP_DIV);
    localparam int c_lim   = lim_calc(ACC_W, DELTA_W);
    localparam logic signed [ACC_W-1:0] c_lim_lo   = ACC_W'(-c_lim);
    localparam logic signed [ACC_W-1:0] c_lim_hi   = ACC_W'(c_lim - 1);
    localparam logic [c_div_w-1:0]      c_div_last = c_div_w'(STEP_DIV - 1);

    logic [c_div_w-1:0]      r_div;
    logic                    w_step;
    logic                    w_accept;
    logic signed [ACC_W-1:0] w_acc_x;
    logic signed [ACC_W-1:0] w_acc_y;

    // Ce-pulse divider; free running, never disturbed by accepts
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_div <= '0;
        end else if (ce) begin
            r_div <= (r_div == c_div_last) ? '0 : r_div + c_div_w'(1);
        end
    end

`ifdef TRACKBALL_ACCEL_EN
    localparam logic signed [ACC_W-1:0] c_thr_hi = ACC_W'(c_accel_thresh);
    localparam logic signed [ACC_W-1:0] c_thr_lo = ACC_W'(-c_accel_thresh);
    logic w_fast;

    // Either axis far from zero speeds up the shared step rate
    always_comb begin
        w_fast = (w_acc_x > c_thr_hi) || (w_acc_x < c_thr_lo) ||
                 (w_acc_y > c_thr_hi) || (w_acc_y < c_thr_lo);
    end

    assign w_step = ce && ((w_fast && (r_div[1:0] == 2'b11)) || (r_div == c_div_last));
`else
    assign w_step = ce && (r_div == c_div_last);
`endif

    // Ready only while both accumulators keep room for a worst-case delta
    assign delta_ready = (w_acc_x >= c_lim_lo) && (w_acc_x <= c_lim_hi) &&
                         (w_acc_y >= c_lim_lo) && (w_acc_y <= c_lim_hi);
    assign w_accept    = delta_valid && delta_ready;
    assign busy        = (w_acc_x != '0) || (w_acc_y != '0);

    quad_axis #(
        .DELTA_W (DELTA_W),
        .ACC_W   (ACC_W)
    ) u_axis_x (
        .clk     (clk),
        .reset_n (reset_n),
        .i_step  (w_step),
        .i_load  (w_accept),
        .i_delta (delta_x),
        .o_a     (xa),
        .o_b     (xb),
        .o_acc   (w_acc_x)
    );

    quad_axis #(
        .DELTA_W (DELTA_W),
        .ACC_W   (ACC_W)
    ) u_axis_y (
        .clk     (clk),
        .reset_n (reset_n),
        .i_step  (w_step),
        .i_load  (w_accept),
        .i_delta (delta_y),
        .o_a     (ya),
        .o_b     (yb),
        .o_acc   (w_acc_y)
    );

endmodule
`default_nettype wire
